detection_result_merger: RTL and testbench

DETECTION_RESULT_MERGER -- requirements
Module: detection_result_merger

---
 rtl/detection_pkg.sv | 25 ++
 rtl/detection_result_fifo.sv | 61 ++++++
 rtl/detection_result_merger.sv | 148 ++++++++++++++
 tb/tb_detection_result_merger.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/detection_pkg.sv
// Shared constants for the detection result merger: memory-port default widths,
// detection window sizes and the channel-index width helper.
package detection_pkg;

  localparam int ADDR_W_DEFAULT = 13;
  localparam int DATA_W_DEFAULT = 32;

  localparam int WIN_SIZE_CH0 = 23;
  localparam int WIN_SIZE_CH1 = 19;
  localparam int WIN_SIZE_CH2 = 17;

  // Keeps channel-index ports at least one bit wide for a single-channel build.
  function automatic int chIdxWidth(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

  function automatic int winSize(input int ch);
    case (ch)
      0:       return WIN_SIZE_CH0;
      1:       return WIN_SIZE_CH1;
      default: return WIN_SIZE_CH2;
    endcase
  endfunction

endpackage

// File: rtl/detection_result_fifo.sv
// One channel's result FIFO: first-word-fall-through read, registered full/empty,
// a push into a full FIFO is refused even if a pop happens on the same edge.
module detection_result_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 45,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iData,
  input  logic             iPop,
  output logic [WIDTH-1:0] oData,
  output logic [CNT_W-1:0] oCount,
  output logic             oFull,
  output logic             oEmpty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             pushOk;
  logic             popOk;
  logic [CNT_W-1:0] countNext;

  assign pushOk = iPush && !oFull;
  assign popOk  = iPop && !oEmpty;
  // Asynchronous read so the head entry reaches the output slot on the next edge.
  assign oData  = mem[rdPtr];

  always_comb begin
    countNext = oCount;
    if (pushOk && !popOk) begin
      countNext = oCount + CNT_W'(1);
    end else if (popOk && !pushOk) begin
      countNext = oCount - CNT_W'(1);
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      oCount <= '0;
      oFull  <= 1'b0;
      oEmpty <= 1'b1;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PTR_W'(1);
      if (popOk)  rdPtr <= rdPtr + PTR_W'(1);
      oCount <= countNext;
      oFull  <= (countNext == CNT_W'(DEPTH));
      oEmpty <= (countNext == '0);
    end
  end

  always_ff @(posedge iClk) begin
    if (pushOk) mem[wrPtr] <= iData;
  end

endmodule

// File: rtl/detection_result_merger.sv
// Merges per-window detection results into one output-memory write stream with
// round-robin arbitration. Define DETECTION_MERGER_STATS_EN to add oHit_count.
module detection_result_merger
  import detection_pkg::*;
#(
  parameter  int NUM_CH     = 3,
  parameter  int ADDR_W     = ADDR_W_DEFAULT,
  parameter  int DATA_W     = DATA_W_DEFAULT,
  parameter  int FIFO_DEPTH = 4,
  localparam int CH_W       = chIdxWidth(NUM_CH)
) (
  input  logic                     iClk,
  input  logic                     iReset,
  input  logic                     iFrame_start,
  input  logic [NUM_CH-1:0]        iWrreq_OM,
  input  logic [NUM_CH*ADDR_W-1:0] iAddr_OM,
  input  logic [NUM_CH*DATA_W-1:0] iData_out,
  input  logic [NUM_CH-1:0]        iFinish,
  input  logic                     iWait_OM,
  output logic [NUM_CH-1:0]        oFull,
  output logic [NUM_CH-1:0]        oOverflow,
  output logic                     oWrreq_OM,
  output logic [ADDR_W-1:0]        oAddr_OM,
  output logic [DATA_W-1:0]        oData_OM,
  output logic [CH_W-1:0]          oCh_OM,
  output logic                     oFrame_done
`ifdef DETECTION_MERGER_STATS_EN
  ,
  output logic [NUM_CH*16-1:0]     oHit_count
`endif
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CH-1:0] fifoPop;
  logic [NUM_CH-1:0] fifoEmpty;
  logic [ENT_W-1:0]  fifoOut   [NUM_CH];
  logic [CNT_W-1:0]  fifoCount [NUM_CH];
  logic [CH_W-1:0]   lastGrant;
  logic [CH_W-1:0]   grantIdx;
  logic              grantValid;
  logic              slotFree;
  logic              slotLoad;
  logic              allEmpty;
  logic              fired;
  logic [NUM_CH-1:0] done;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : gCh
      detection_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
      ) uFifo (
        .iClk   (iClk),
        .iReset (iReset),
        .iPush  (iWrreq_OM[gi]),
        .iData  ({iAddr_OM[gi*ADDR_W +: ADDR_W], iData_out[gi*DATA_W +: DATA_W]}),
        .iPop   (fifoPop[gi]),
        .oData  (fifoOut[gi]),
        .oCount (fifoCount[gi]),
        .oFull  (oFull[gi]),
        .oEmpty (fifoEmpty[gi])
      );
      assign fifoPop[gi] = slotLoad && (grantIdx == CH_W'(gi));
    end
  endgenerate

  // Descending scan: the last hit is the nearest non-empty channel after lastGrant.
  always_comb begin
    grantIdx   = '0;
    grantValid = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (!fifoEmpty[CH_W'((int'(lastGrant) + k) % NUM_CH)]) begin
        grantIdx   = CH_W'((int'(lastGrant) + k) % NUM_CH);
        grantValid = 1'b1;
      end
    end
  end

  always_comb begin
    allEmpty = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (fifoCount[k] != '0) allEmpty = 1'b0;
    end
  end

  assign slotFree    = !oWrreq_OM || !iWait_OM;
  assign slotLoad    = slotFree && grantValid;
  assign oFrame_done = (&done) && allEmpty && !oWrreq_OM && !fired;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      oWrreq_OM <= 1'b0;
      oAddr_OM  <= '0;
      oData_OM  <= '0;
      oCh_OM    <= '0;
      lastGrant <= CH_W'(NUM_CH - 1);
      done      <= '0;
      oOverflow <= '0;
      fired     <= 1'b0;
    end else begin
      if (slotFree) begin
        oWrreq_OM <= grantValid;
        if (grantValid) begin
          {oAddr_OM, oData_OM} <= fifoOut[grantIdx];
          oCh_OM               <= grantIdx;
        end
      end
      // A new frame overrides same-edge finish, overflow and grant updates.
      if (iFrame_start) begin
        lastGrant <= CH_W'(NUM_CH - 1);
        done      <= '0;
        oOverflow <= '0;
        fired     <= 1'b0;
      end else begin
        if (slotLoad)    lastGrant <= grantIdx;
        done      <= done | iFinish;
        oOverflow <= oOverflow | (iWrreq_OM & oFull);
        if (oFrame_done) fired <= 1'b1;
      end
    end
  end

`ifdef DETECTION_MERGER_STATS_EN
  logic        xfer;
  logic [15:0] hitCount [NUM_CH];

  assign xfer = oWrreq_OM && !iWait_OM;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : gHit
      always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
          hitCount[gi] <= '0;
        end else if (iFrame_start) begin
          hitCount[gi] <= '0;
        end else if (xfer && (oCh_OM == CH_W'(gi)) && (hitCount[gi] != 16'hFFFF)) begin
          hitCount[gi] <= hitCount[gi] + 16'd1;
        end
      end
      assign oHit_count[gi*16 +: 16] = hitCount[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_detection_result_merger.sv
// Bench for detection_result_merger: vector table, directed corner sequences and
// randomized traffic against a queue-level reference model.
module tb_detection_result_merger;

  localparam int NUM_CH = 3;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int ENT_W  = ADDR_W + DATA_W;
  localparam int NV     = 16;

  logic                     iClk = 1'b0;
  logic                     iReset;
  logic                     iFrame_start;
  logic [NUM_CH-1:0]        iWrreq_OM;
  logic [NUM_CH*ADDR_W-1:0] iAddr_OM;
  logic [NUM_CH*DATA_W-1:0] iData_out;
  logic [NUM_CH-1:0]        iFinish;
  logic                     iWait_OM;
  logic [NUM_CH-1:0]        oFull;
  logic [NUM_CH-1:0]        oOverflow;
  logic                     oWrreq_OM;
  logic [ADDR_W-1:0]        oAddr_OM;
  logic [DATA_W-1:0]        oData_OM;
  logic [1:0]               oCh_OM;
  logic                     oFrame_done;
`ifdef DETECTION_MERGER_STATS_EN
  logic [NUM_CH*16-1:0]     oHit_count;
`endif

  detection_result_merger #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .iClk         (iClk),
    .iReset       (iReset),
    .iFrame_start (iFrame_start),
    .iWrreq_OM    (iWrreq_OM),
    .iAddr_OM     (iAddr_OM),
    .iData_out    (iData_out),
    .iFinish      (iFinish),
    .iWait_OM     (iWait_OM),
    .oFull        (oFull),
    .oOverflow    (oOverflow),
    .oWrreq_OM    (oWrreq_OM),
    .oAddr_OM     (oAddr_OM),
    .oData_OM     (oData_OM),
    .oCh_OM       (oCh_OM),
    .oFrame_done  (oFrame_done)
`ifdef DETECTION_MERGER_STATS_EN
    ,
    .oHit_count   (oHit_count)
`endif
  );

  always #5 iClk = ~iClk;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-channel arrays used as queues, plus the output slot.
  logic [ENT_W-1:0]  mFifo [NUM_CH][DEPTH];
  int                mCnt  [NUM_CH];
  logic              mSlotV;
  logic [ADDR_W-1:0] mSlotA;
  logic [DATA_W-1:0] mSlotD;
  int                mSlotCh;
  int                mLast;
  logic [NUM_CH-1:0] mDone;
  logic [NUM_CH-1:0] mOvf;
  logic              mFired;
  int                mAcc;

  logic [33:0] dutLog [$];

  typedef struct packed {
    logic [2:0]  wr;
    logic [12:0] a;
    logic [31:0] d;
    logic        wt;
    logic        expWr;
    logic [1:0]  expCh;
    logic [12:0] expA;
    logic [31:0] expD;
  } vec_t;

  vec_t tv [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [2:0] wr, input logic [12:0] a, input logic [31:0] d,
                               input logic wt, input logic ew, input logic [1:0] ec,
                               input logic [12:0] ea, input logic [31:0] ed);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.wt = wt;
    v.expWr = ew; v.expCh = ec; v.expA = ea; v.expD = ed;
    return v;
  endfunction

  function automatic void modelReset();
    for (int c = 0; c < NUM_CH; c++) mCnt[c] = 0;
    mSlotV = 1'b0; mSlotA = '0; mSlotD = '0; mSlotCh = 0;
    mLast = NUM_CH - 1; mDone = '0; mOvf = '0; mFired = 1'b0; mAcc = 0;
  endfunction

  function automatic logic modelFrameDone();
    logic empty;
    empty = 1'b1;
    for (int c = 0; c < NUM_CH; c++) if (mCnt[c] != 0) empty = 1'b0;
    return (&mDone) && empty && !mSlotV && !mFired;
  endfunction

  function automatic void modelStep();
    logic [NUM_CH-1:0] preFull;
    logic [NUM_CH-1:0] rej;
    logic              fdPre;
    int                pick;
    int                ch;
    fdPre = modelFrameDone();
    rej   = '0;
    for (int c = 0; c < NUM_CH; c++) preFull[c] = (mCnt[c] == DEPTH);
    pick = -1;
    if (!mSlotV || !iWait_OM) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        ch = (mLast + k) % NUM_CH;
        if (pick < 0 && mCnt[ch] > 0) pick = ch;
      end
      if (pick >= 0) begin
        {mSlotA, mSlotD} = mFifo[pick][0];
        for (int i = 0; i < DEPTH - 1; i++) mFifo[pick][i] = mFifo[pick][i+1];
        mCnt[pick]--;
        mSlotV  = 1'b1;
        mSlotCh = pick;
      end else begin
        mSlotV = 1'b0;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (iWrreq_OM[c]) begin
        if (!preFull[c]) begin
          mFifo[c][mCnt[c]] = {iAddr_OM[c*ADDR_W +: ADDR_W], iData_out[c*DATA_W +: DATA_W]};
          mCnt[c]++;
          mAcc++;
        end else begin
          rej[c] = 1'b1;
        end
      end
    end
    if (iFrame_start) begin
      mLast = NUM_CH - 1; mDone = '0; mOvf = '0; mFired = 1'b0;
    end else begin
      if (pick >= 0) mLast = pick;
      mDone  = mDone | iFinish;
      mOvf   = mOvf | rej;
      mFired = mFired | fdPre;
    end
  endfunction

  task automatic checkOutputs();
    logic [NUM_CH-1:0] expFull;
    for (int c = 0; c < NUM_CH; c++) expFull[c] = (mCnt[c] == DEPTH);
    chk("wrreq", 64'(oWrreq_OM), 64'(mSlotV));
    if (mSlotV) begin
      chk("addr", 64'(oAddr_OM), 64'(mSlotA));
      chk("data", 64'(oData_OM), 64'(mSlotD));
      chk("ch", 64'(oCh_OM), 64'(mSlotCh));
    end
    chk("full", 64'(oFull), 64'(expFull));
    chk("overflow", 64'(oOverflow), 64'(mOvf));
    chk("frame_done", 64'(oFrame_done), 64'(modelFrameDone()));
  endtask

  task automatic setIdle();
    iFrame_start = 1'b0; iWrreq_OM = '0; iAddr_OM = '0; iData_out = '0;
    iFinish = '0; iWait_OM = 1'b0;
  endtask

  task automatic setAll(input logic [2:0] wr, input logic [12:0] a, input logic [31:0] d);
    iWrreq_OM = wr;
    for (int c = 0; c < NUM_CH; c++) begin
      iAddr_OM[c*ADDR_W +: ADDR_W] = a;
      iData_out[c*DATA_W +: DATA_W] = d;
    end
  endtask

  task automatic step();
    if (oWrreq_OM && !iWait_OM) dutLog.push_back({oCh_OM, oData_OM});
    @(posedge iClk);
    modelStep();
    #1;
    checkOutputs();
  endtask

  task automatic doReset();
    iReset = 1'b1;
    setIdle();
    #2;
    chk("rst_wrreq", 64'(oWrreq_OM), 64'd0);
    chk("rst_addr", 64'(oAddr_OM), 64'd0);
    chk("rst_data", 64'(oData_OM), 64'd0);
    chk("rst_ch", 64'(oCh_OM), 64'd0);
    chk("rst_full", 64'(oFull), 64'd0);
    chk("rst_overflow", 64'(oOverflow), 64'd0);
    chk("rst_frame_done", 64'(oFrame_done), 64'd0);
    modelReset();
    dutLog.delete();
    @(posedge iClk);
    #1;
    iReset = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    int dups;
    int ch0cnt;
    logic [NUM_CH-1:0] seenFull;

    setIdle();
    doReset();

    tv[0]  = mkv(3'b010, 13'h0A5, 32'h12345678, 1'b0, 1'b0, 2'd0, 13'h000, 32'h0);
    tv[1]  = mkv(3'b000, 13'h000, 32'h0,        1'b0, 1'b1, 2'd1, 13'h0A5, 32'h12345678);
    tv[2]  = mkv(3'b000, 13'h000, 32'h0,        1'b0, 1'b0, 2'd0, 13'h000, 32'h0);
    tv[3]  = mkv(3'b111, 13'h111, 32'hAAAA0001, 1'b0, 1'b0, 2'd0, 13'h000, 32'h0);
    tv[4]  = mkv(3'b000, 13'h000, 32'h0,        1'b0, 1'b1, 2'd2, 13'h111, 32'hAAAA0001);
    tv[5]  = mkv(3'b000, 13'h000, 32'h0,        1'b0, 1'b1, 2'd0, 13'h111, 32'hAAAA0001);
    tv[6]  = mkv(3'b000, 13'h000, 32'h0,        1'b0, 1'b1, 2'd1, 13'h111, 32'hAAAA0001);
    tv[7]  = mkv(3'b000, 13'h000, 32'h0,        1'b0, 1'b0, 2'd0, 13'h000, 32'h0);
    tv[8]  = mkv(3'b001, 13'h010, 32'h00000055, 1'b1, 1'b0, 2'd0, 13'h000, 32'h0);
    tv[9]  = mkv(3'b000, 13'h000, 32'h0,        1'b1, 1'b1, 2'd0, 13'h010, 32'h00000055);
    tv[10] = mkv(3'b000, 13'h000, 32'h0,        1'b1, 1'b1, 2'd0, 13'h010, 32'h00000055);
    tv[11] = mkv(3'b000, 13'h000, 32'h0,        1'b0, 1'b0, 2'd0, 13'h000, 32'h0);
    tv[12] = mkv(3'b101, 13'h020, 32'h00000066, 1'b0, 1'b0, 2'd0, 13'h000, 32'h0);
    tv[13] = mkv(3'b000, 13'h000, 32'h0,        1'b0, 1'b1, 2'd2, 13'h020, 32'h00000066);
    tv[14] = mkv(3'b000, 13'h000, 32'h0,        1'b0, 1'b1, 2'd0, 13'h020, 32'h00000066);
    tv[15] = mkv(3'b000, 13'h000, 32'h0,        1'b0, 1'b0, 2'd0, 13'h000, 32'h0);

    for (int i = 0; i < NV; i++) begin
      setIdle();
      setAll(tv[i].wr, tv[i].a, tv[i].d);
      iWait_OM = tv[i].wt;
      step();
      chk("tv_wrreq", 64'(oWrreq_OM), 64'(tv[i].expWr));
      if (tv[i].expWr) begin
        chk("tv_ch", 64'(oCh_OM), 64'(tv[i].expCh));
        chk("tv_addr", 64'(oAddr_OM), 64'(tv[i].expA));
        chk("tv_data", 64'(oData_OM), 64'(tv[i].expD));
      end
      $display("vec %0d: wr=%b wait=%b -> oWrreq=%b ch=%0d addr=%h data=%h",
               i, tv[i].wr, tv[i].wt, oWrreq_OM, oCh_OM, oAddr_OM, oData_OM);
    end

    // Three-channel burst: ordering, full, overflow, no duplicates.
    doReset();
    seenFull = '0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      setIdle();
      iWrreq_OM = 3'b111;
      for (int c = 0; c < NUM_CH; c++) begin
        iAddr_OM[c*ADDR_W +: ADDR_W]  = 13'(c * 16 + cyc);
        iData_out[c*DATA_W +: DATA_W] = {8'(c), 24'(cyc)};
      end
      step();
      seenFull |= oFull;
    end
    setIdle();
    for (int i = 0; i < 30; i++) begin
      step();
      seenFull |= oFull;
    end
    chk("burst_count", 64'(dutLog.size()), 64'(mAcc));
    chk("burst_order0", 64'(dutLog[0][33:32]), 64'd0);
    chk("burst_order1", 64'(dutLog[1][33:32]), 64'd1);
    chk("burst_order2", 64'(dutLog[2][33:32]), 64'd2);
    chk("burst_order3", 64'(dutLog[3][33:32]), 64'd0);
    chk("burst_seen_full", 64'(seenFull), 64'h7);
    chk("burst_overflow", 64'(oOverflow), 64'h7);
    dups = 0;
    for (int i = 0; i < dutLog.size(); i++)
      for (int j = i + 1; j < dutLog.size(); j++)
        if (dutLog[i][31:0] == dutLog[j][31:0]) dups++;
    chk("burst_no_dup", 64'(dups), 64'd0);
    $display("burst: %0d results merged", dutLog.size());

    // Stall for five cycles with the slot valid.
    doReset();
    setIdle();
    iWrreq_OM = 3'b100;
    iAddr_OM[2*ADDR_W +: ADDR_W]  = 13'h1C3;
    iData_out[2*DATA_W +: DATA_W] = 32'hCAFEF00D;
    step();
    setIdle();
    iWait_OM = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_hold", 64'({oWrreq_OM, oCh_OM, oAddr_OM, oData_OM}),
          64'({1'b1, 2'd2, 13'h1C3, 32'hCAFEF00D}));
    end
    n = dutLog.size();
    iWait_OM = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("stall_one_xfer", 64'(dutLog.size() - n), 64'd1);
    $display("stall: released after 5 held cycles");

    // Five writes on ch0 behind a stalled slot: fifth is dropped.
    doReset();
    setIdle();
    iWrreq_OM = 3'b010;
    iAddr_OM[ADDR_W +: ADDR_W] = 13'h00B;
    step();
    setIdle();
    iWait_OM = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      setIdle();
      iWait_OM = 1'b1;
      iWrreq_OM = 3'b001;
      iAddr_OM[0 +: ADDR_W]  = 13'(16'h40 + i);
      iData_out[0 +: DATA_W] = 32'(i);
      step();
    end
    chk("ovf_full0", 64'(oFull[0]), 64'd1);
    chk("ovf_flag0", 64'(oOverflow[0]), 64'd1);
    setIdle();
    iWait_OM = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("ovf_sticky", 64'(oOverflow[0]), 64'd1);
    iFrame_start = 1'b1;
    step();
    chk("ovf_cleared", 64'(oOverflow[0]), 64'd0);
    chk("ovf_full_kept", 64'(oFull[0]), 64'd1);
    setIdle();
    n = dutLog.size();
    for (int i = 0; i < 10; i++) step();
    ch0cnt = 0;
    for (int i = n; i < dutLog.size(); i++) if (dutLog[i][33:32] == 2'd0) ch0cnt++;
    chk("ovf_ch0_drained", 64'(ch0cnt), 64'd4);
    $display("overflow: %0d ch0 results delivered", ch0cnt);

    // Frame completion pulse.
    doReset();
    setIdle();
    setAll(3'b111, 13'h055, 32'h0F0F0F0F);
    iFinish = 3'b111;
    step();
    setIdle();
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (oFrame_done) pulses++;
    end
    chk("fd_pulses", 64'(pulses), 64'd1);
    $display("frame_done: %0d pulse(s)", pulses);

    // Reset in the middle of a burst, then a fresh frame.
    for (int i = 0; i < 4; i++) begin
      setIdle();
      setAll(3'b111, 13'(i), 32'(i));
      step();
    end
    doReset();
    setIdle();
    setAll(3'b111, 13'h077, 32'h77);
    step();
    setIdle();
    for (int i = 0; i < 5; i++) step();
    chk("rst_fresh_count", 64'(dutLog.size()), 64'd3);
    chk("rst_fresh_first", 64'(dutLog[0][33:32]), 64'd0);
    chk("rst_fresh_second", 64'(dutLog[1][33:32]), 64'd1);
    $display("reset: fresh frame merged %0d results", dutLog.size());

    // Randomized traffic against the model.
    doReset();
    for (int i = 0; i < 400; i++) begin
      setIdle();
      if ((i % 100) < 60) iWrreq_OM = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 5) == 0) iWrreq_OM = 3'(1 << $urandom_range(0, 2));
      for (int c = 0; c < NUM_CH; c++) begin
        iAddr_OM[c*ADDR_W +: ADDR_W]  = 13'($urandom);
        iData_out[c*DATA_W +: DATA_W] = $urandom;
      end
      iWait_OM     = ($urandom_range(0, 3) == 0);
      iFinish      = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      iFrame_start = ($urandom_range(0, 59) == 0);
      step();
    end
    $display("random: %0d results merged", dutLog.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
